// File: rtl/alu_operand_fifo_if.sv
// rtl/alu_operand_fifo_if.sv - operand source / adder handshake bundle for alu_operand_fifo
interface alu_operand_fifo_if #(
  parameter int DATA_SIZE = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_add_1;
  logic [DATA_SIZE-1:0] in_add_2;
  logic                 in_c_in;
  logic                 a_valid_f_data;
  logic                 a_ready_f_data;
  logic [DATA_SIZE-1:0] add_1;
  logic [DATA_SIZE-1:0] add_2;
  logic                 c_in;

  modport master (
    output in_valid, in_add_1, in_add_2, in_c_in, a_ready_f_data,
    input  in_ready, a_valid_f_data, add_1, add_2, c_in
  );

  modport slave (
    input  in_valid, in_add_1, in_add_2, in_c_in, a_ready_f_data,
    output in_ready, a_valid_f_data, add_1, add_2, c_in
  );
endinterface

// File: rtl/alu_operand_fifo.sv
// rtl/alu_operand_fifo.sv - in-order operand-set buffer feeding the ripple-carry adder
module alu_operand_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  alu_operand_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * DATA_SIZE + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               in_ready_q;
  logic               a_valid_q;
  logic               push;
  logic               pop;
  logic [ADDR_W:0]    count_next;
  logic [ENTRY_W-1:0] head;

  assign push       = bus.in_valid & in_ready_q;
  assign pop        = a_valid_q & bus.a_ready_f_data;
  assign count_next = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

  // Head is read straight from storage; a push only lands on rd_ptr when empty.
  assign head               = mem[rd_ptr];
  assign bus.add_1          = head[ENTRY_W-1 -: DATA_SIZE];
  assign bus.add_2          = head[DATA_SIZE:1];
  assign bus.c_in           = head[0];
  assign bus.in_ready       = in_ready_q;
  assign bus.a_valid_f_data = a_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
      a_valid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
      a_valid_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.in_add_1, bus.in_add_2, bus.in_c_in};
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count      <= count_next;
      in_ready_q <= (count_next != (ADDR_W+1)'(DEPTH));
      a_valid_q  <= (count_next != '0);
    end
  end
endmodule

// File: tb/tb_alu_operand_fifo.sv
// tb/tb_alu_operand_fifo.sv - randomized and directed bench for alu_operand_fifo
module tb_alu_operand_fifo;
  localparam int DS    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;

  alu_operand_fifo_if #(.DATA_SIZE(DS)) bus ();

  alu_operand_fifo #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;

  logic [16:0] q[$];
  logic [16:0] src_q[$];
  bit          m_ready;
  bit          m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
    chk("a_valid", {31'd0, bus.a_valid_f_data}, {31'd0, m_valid});
    chk("count", {29'd0, count}, q.size());
    if (m_valid) begin
      chk("add_1", {24'd0, bus.add_1}, {24'd0, q[0][16:9]});
      chk("add_2", {24'd0, bus.add_2}, {24'd0, q[0][8:1]});
      chk("c_in", {31'd0, bus.c_in}, {31'd0, q[0][0]});
    end
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_a_valid", {31'd0, bus.a_valid_f_data}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_add_1", {24'd0, bus.add_1}, 0);
    chk("rst_add_2", {24'd0, bus.add_2}, 0);
    chk("rst_c_in", {31'd0, bus.c_in}, 0);
  endtask

  task automatic model_reset();
    q.delete();
    src_q.delete();
    m_ready = 0;
    m_valid = 0;
  endtask

  // Called in the phase just after a rising edge; ends in the same phase one cycle later.
  task automatic cycle(input bit want_v, input bit rdy, input bit fl);
    bit          push, pop;
    logic [16:0] d;
    d = (src_q.size() != 0) ? src_q[0] : 17'd0;
    bus.in_valid       = want_v && (src_q.size() != 0);
    bus.in_add_1       = d[16:9];
    bus.in_add_2       = d[8:1];
    bus.in_c_in        = d[0];
    bus.a_ready_f_data = rdy;
    flush              = fl;
    @(negedge clk);
    check_outputs();
    if (bus.a_valid_f_data && bus.a_ready_f_data) n_hs++;
    push = bus.in_valid && m_ready;
    pop  = m_valid && rdy;
    @(posedge clk);
    #1;
    if (push) void'(src_q.pop_front());
    if (fl) begin
      q.delete();
      m_ready = 1;
      m_valid = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      m_ready = (q.size() != DEPTH);
      m_valid = (q.size() != 0);
    end
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_ready_f_data = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int hs0;
    bus.in_valid = 0; bus.in_add_1 = 0; bus.in_add_2 = 0; bus.in_c_in = 0;
    bus.a_ready_f_data = 0;
    model_reset();

    // 1: reset, in_ready low first cycle then high
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // 2: single set
    src_q.push_back({8'h12, 8'h34, 1'b1});
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // 3 and 4: fill, hold off fifth, one pop while full, then drain
    for (int i = 1; i <= 5; i++) src_q.push_back({i[7:0], 8'(i + 8'h40), i[0]});
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    chk("fill_src_held", src_q.size(), 1);
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("fifth_taken", src_q.size(), 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);

    // 5: streaming with occupancy held at 2
    for (int i = 0; i < 22; i++) src_q.push_back(17'($urandom));
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    hs0 = n_hs;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0);
      chk("stream_count", {29'd0, count}, 2);
    end
    chk("stream_pops", n_hs - hs0, 20);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);

    // 6a: flush with a concurrent push
    for (int i = 0; i < 4; i++) src_q.push_back(17'($urandom));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    cycle(1, 1, 1);
    cycle(0, 0, 0);
    chk("flush_count", {29'd0, count}, 0);

    // 6b: asynchronous reset away from the clock edge
    src_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(17'($urandom));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() == 0) src_q.push_back(17'($urandom));
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
